// File: rtl/i2c_pkg.sv
// ---------------------------------------------------------------------------
// i2c_pkg
// Shared types and helpers for the I2C register-memory slave.
//   state_e    : slave frame FSM states
//   I2C_ADDR_W : register address width (7)
//   I2C_DATA_W : register data width (8)
//   addr_ok()  : 1 when a register address falls inside a memory of 'depth' entries
// ---------------------------------------------------------------------------
package i2c_pkg;

  localparam int I2C_ADDR_W = 7;
  localparam int I2C_DATA_W = 8;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ADDR  = 3'd1,
    S_ACK1  = 3'd2,
    S_WDATA = 3'd3,
    S_ACK2  = 3'd4,
    S_RDATA = 3'd5
  } state_e;

  // The address is widened by one bit so that a 128-entry memory gives a
  // real comparison rather than one that is constant-true.
  function automatic logic addr_ok(input logic [I2C_ADDR_W-1:0] addr, input int depth);
    return {1'b0, addr} < 8'(depth);
  endfunction

endpackage

// File: rtl/i2c_slave_regfile.sv
// ---------------------------------------------------------------------------
// i2c_slave_regfile
// MEM_DEPTH x 8 register array with a synchronous active-low reset fill,
// one write port from the I2C engine and a combinational read port.
// Optional macro I2C_SLAVE_HOST_PORT_EN adds a host write/read port; on the
// same address in the same cycle the host write takes priority.
// Ports:
//   clk, rst                 clock, synchronous active-low reset
//   we, waddr, wdata         I2C write port (ignored for waddr >= MEM_DEPTH)
//   raddr, rdata             I2C read port (reads 0 for raddr >= MEM_DEPTH)
//   host_we, host_addr,      host write port           (macro only)
//   host_wdata, host_rdata   host combinational read   (macro only)
// ---------------------------------------------------------------------------
module i2c_slave_regfile
  import i2c_pkg::*;
#(
  parameter int              MEM_DEPTH  = 128,
  parameter logic [7:0]      RESET_FILL = 8'h00
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [I2C_ADDR_W-1:0] waddr,
  input  logic [I2C_DATA_W-1:0] wdata,
  input  logic [I2C_ADDR_W-1:0] raddr,
  output logic [I2C_DATA_W-1:0] rdata
`ifdef I2C_SLAVE_HOST_PORT_EN
  ,
  input  logic                  host_we,
  input  logic [I2C_ADDR_W-1:0] host_addr,
  input  logic [I2C_DATA_W-1:0] host_wdata,
  output logic [I2C_DATA_W-1:0] host_rdata
`endif
);

  // The array is rounded up to a power of two so index width matches exactly;
  // entries at or above MEM_DEPTH are never written or read.
  localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam int SLOTS = 1 << IDX_W;

  logic [I2C_DATA_W-1:0] mem_q [SLOTS];
  logic [I2C_DATA_W-1:0] mem_d [SLOTS];
  logic [IDX_W-1:0]      widx;
  logic [IDX_W-1:0]      ridx;

  assign widx  = waddr[IDX_W-1:0];
  assign ridx  = raddr[IDX_W-1:0];
  assign rdata = addr_ok(raddr, MEM_DEPTH) ? mem_q[ridx] : '0;

`ifdef I2C_SLAVE_HOST_PORT_EN
  logic [IDX_W-1:0] hidx;
  assign hidx       = host_addr[IDX_W-1:0];
  assign host_rdata = addr_ok(host_addr, MEM_DEPTH) ? mem_q[hidx] : '0;
`endif

  always_comb begin
    mem_d = mem_q;
    if (we && addr_ok(waddr, MEM_DEPTH)) mem_d[widx] = wdata;
`ifdef I2C_SLAVE_HOST_PORT_EN
    // Applied last so the host byte wins a same-address collision.
    if (host_we && addr_ok(host_addr, MEM_DEPTH)) mem_d[hidx] = host_wdata;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      // NOTE: the memory is deliberately reset (every entry to RESET_FILL), so
      // it maps to flops rather than a RAM macro; that is the intended contract.
      for (int i = 0; i < SLOTS; i++) mem_q[i] <= RESET_FILL;
    end else begin
      mem_q <= mem_d;
    end
  end

endmodule

// File: rtl/i2c_slave_mem.sv
// ---------------------------------------------------------------------------
// i2c_slave_mem
// I2C-style slave holding a MEM_DEPTH x 8 register memory, clocked by scl.
// Each frame: start (sda 1->0 in idle), rw bit, 7 address bits LSB first,
// slave ACK, then one data byte LSB first (written by the master for rw=1,
// driven by the slave for rw=0). Out-of-range addresses are NACKed.
// Optional macro I2C_SLAVE_HOST_PORT_EN adds a local host port.
// Ports:
//   scl        bus clock, all logic on posedge
//   rst        synchronous reset, active-low
//   sda        open bus line; driven only while the slave acks or reads
//   busy       1 while a frame is in progress
//   wr_done    1-cycle pulse after a byte is committed to memory
//   rd_done    1-cycle pulse after the last read bit was driven
//   last_addr  address of the most recent ACKed frame
//   last_wdata byte of the most recent committed write
//   nack       1-cycle pulse when an address is rejected
//   host_we/host_addr/host_wdata/host_rdata/host_coll  (macro only)
// ---------------------------------------------------------------------------
module i2c_slave_mem
  import i2c_pkg::*;
#(
  parameter int         MEM_DEPTH  = 128,
  parameter int         ACK_CYCLES = 1,
  parameter logic [7:0] RESET_FILL = 8'h00
) (
  input  logic                  scl,
  input  logic                  rst,
  inout  wire                   sda,
  output logic                  busy,
  output logic                  wr_done,
  output logic                  rd_done,
  output logic [I2C_ADDR_W-1:0] last_addr,
  output logic [I2C_DATA_W-1:0] last_wdata,
  output logic                  nack
`ifdef I2C_SLAVE_HOST_PORT_EN
  ,
  input  logic                  host_we,
  input  logic [I2C_ADDR_W-1:0] host_addr,
  input  logic [I2C_DATA_W-1:0] host_wdata,
  output logic [I2C_DATA_W-1:0] host_rdata,
  output logic                  host_coll
`endif
);

  localparam logic [2:0] ACK_LAST = 3'(ACK_CYCLES - 1);

  state_e                state_q, state_d;
  logic [2:0]            bit_cnt_q, bit_cnt_d;
  logic                  sda_prev_q, sda_prev_d;
  logic                  rw_q, rw_d;
  logic [I2C_ADDR_W-1:0] addr_q, addr_d;
  logic [I2C_DATA_W-1:0] shift_q, shift_d;
  logic                  sda_oe_q, sda_oe_d;
  logic                  sda_out_q, sda_out_d;
  logic                  wr_done_q, wr_done_d;
  logic                  rd_done_q, rd_done_d;
  logic                  nack_q, nack_d;
  logic [I2C_ADDR_W-1:0] last_addr_q, last_addr_d;
  logic [I2C_DATA_W-1:0] last_wdata_q, last_wdata_d;

  logic                  sda_in;
  logic                  mem_we;
  logic [I2C_DATA_W-1:0] mem_wdata;
  logic [I2C_DATA_W-1:0] mem_rdata;

  assign sda_in    = sda;
  assign sda       = sda_oe_q ? sda_out_q : 1'bz;
  // The committed byte includes the bit being sampled this cycle.
  assign mem_wdata = {sda_in, shift_q[I2C_DATA_W-1:1]};

  assign busy       = (state_q != S_IDLE);
  assign wr_done    = wr_done_q;
  assign rd_done    = rd_done_q;
  assign nack       = nack_q;
  assign last_addr  = last_addr_q;
  assign last_wdata = last_wdata_q;

  i2c_slave_regfile #(
    .MEM_DEPTH  (MEM_DEPTH),
    .RESET_FILL (RESET_FILL)
  ) u_regfile (
    .clk        (scl),
    .rst        (rst),
    .we         (mem_we),
    .waddr      (addr_q),
    .wdata      (mem_wdata),
    .raddr      (addr_q),
    .rdata      (mem_rdata)
`ifdef I2C_SLAVE_HOST_PORT_EN
    ,
    .host_we    (host_we),
    .host_addr  (host_addr),
    .host_wdata (host_wdata),
    .host_rdata (host_rdata)
`endif
  );

`ifdef I2C_SLAVE_HOST_PORT_EN
  logic host_coll_q, host_coll_d;
  assign host_coll   = host_coll_q;
  assign host_coll_d = host_we && addr_ok(host_addr, MEM_DEPTH) && mem_we && (host_addr == addr_q);
`endif

  always_comb begin
    // NOTE: every _d gets a default before the case, so no branch can leave a
    // signal unassigned and infer a latch.
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    sda_prev_d   = sda_in;
    rw_d         = rw_q;
    addr_d       = addr_q;
    shift_d      = shift_q;
    sda_oe_d     = sda_oe_q;
    sda_out_d    = sda_out_q;
    last_addr_d  = last_addr_q;
    last_wdata_d = last_wdata_q;
    wr_done_d    = 1'b0;
    rd_done_d    = 1'b0;
    nack_d       = 1'b0;
    mem_we       = 1'b0;

    case (state_q)
      S_IDLE: begin
        // sda_prev resets to 0, so a line held low out of reset is not a start.
        if (sda_prev_q && !sda_in) begin
          state_d   = S_ADDR;
          bit_cnt_d = '0;
        end
      end

      S_ADDR: begin
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd0) rw_d = sda_in;
        else                   addr_d = {sda_in, addr_q[I2C_ADDR_W-1:1]};
        if (bit_cnt_q == 3'd7) begin
          if (addr_ok(addr_d, MEM_DEPTH)) begin
            state_d     = S_ACK1;
            sda_oe_d    = 1'b1;
            sda_out_d   = 1'b0;
            last_addr_d = addr_d;
          end else begin
            state_d = S_IDLE;
            nack_d  = 1'b1;
          end
        end
      end

      S_ACK1: begin
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (bit_cnt_q == ACK_LAST) begin
          bit_cnt_d = '0;
          if (rw_q) begin
            state_d  = S_WDATA;
            sda_oe_d = 1'b0;
          end else begin
            // Keep driving; bit 0 of the read byte follows the ACK directly.
            state_d   = S_RDATA;
            sda_out_d = mem_rdata[0];
          end
        end
      end

      S_WDATA: begin
        bit_cnt_d = bit_cnt_q + 3'd1;
        shift_d   = mem_wdata;
        if (bit_cnt_q == 3'd7) begin
          mem_we       = 1'b1;
          last_wdata_d = mem_wdata;
          wr_done_d    = 1'b1;
          state_d      = S_ACK2;
          sda_oe_d     = 1'b1;
          sda_out_d    = 1'b0;
        end
      end

      S_ACK2: begin
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (bit_cnt_q == ACK_LAST) begin
          bit_cnt_d = '0;
          sda_oe_d  = 1'b0;
          state_d   = S_IDLE;
        end
      end

      S_RDATA: begin
        bit_cnt_d = bit_cnt_q + 3'd1;
        sda_out_d = mem_rdata[bit_cnt_d];
        if (bit_cnt_q == 3'd7) begin
          sda_oe_d  = 1'b0;
          rd_done_d = 1'b1;
          state_d   = S_IDLE;
        end
      end

      default: begin
        state_d   = S_IDLE;
        bit_cnt_d = '0;
        sda_oe_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge scl) begin
    // NOTE: non-blocking assignments so every flop updates from the values
    // present before this edge, independent of statement order.
    if (!rst) begin
      state_q      <= S_IDLE;
      bit_cnt_q    <= '0;
      sda_prev_q   <= 1'b0;
      rw_q         <= 1'b0;
      addr_q       <= '0;
      shift_q      <= '0;
      sda_oe_q     <= 1'b0;
      sda_out_q    <= 1'b0;
      wr_done_q    <= 1'b0;
      rd_done_q    <= 1'b0;
      nack_q       <= 1'b0;
      last_addr_q  <= '0;
      last_wdata_q <= '0;
`ifdef I2C_SLAVE_HOST_PORT_EN
      host_coll_q  <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      sda_prev_q   <= sda_prev_d;
      rw_q         <= rw_d;
      addr_q       <= addr_d;
      shift_q      <= shift_d;
      sda_oe_q     <= sda_oe_d;
      sda_out_q    <= sda_out_d;
      wr_done_q    <= wr_done_d;
      rd_done_q    <= rd_done_d;
      nack_q       <= nack_d;
      last_addr_q  <= last_addr_d;
      last_wdata_q <= last_wdata_d;
`ifdef I2C_SLAVE_HOST_PORT_EN
      host_coll_q  <= host_coll_d;
`endif
    end
  end

endmodule
